// File: rtl/amber48_uart_tx.sv
// amber48_uart_tx: 8N1 UART transmitter behind the dmem MMIO UART port.
// Strobed bytes go into a circular FIFO and are shifted out LSB-first.
// The upstream store cannot stall, so bytes that arrive while the FIFO is
// full are dropped and reported through a sticky overflow flag.
module amber48_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_valid_i,
  input  logic [7:0]       tx_data_i,
  input  logic             clr_ovf_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tx_q;
  logic              ovf_q;

  logic              baud_last;
  logic              fifo_full;
  logic              fifo_nempty;
  logic              pop;
  logic              push;

  // Handshake decode: a pop happens whenever the FSM loads a new byte, and a
  // same-cycle pop frees the slot a push into a full FIFO needs.
  always_comb begin
    baud_last   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    fifo_nempty = (count != '0);
    fifo_full   = (count == CNT_W'(FIFO_DEPTH));
    pop         = fifo_nempty &&
                  ((state == IDLE) || ((state == STOP) && baud_last));
    push        = tx_valid_i && (!fifo_full || pop);
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= tx_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop sets it, and a drop wins over a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (tx_valid_i && !push) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_q <= 1'b0;
    end
  end

  // Frame FSM; tx_q is loaded with the value of the state being entered so
  // the line is registered without a cycle of extra latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state != IDLE) || fifo_nempty;
  assign fifo_count_o = count;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Self-checking bench for amber48_uart_tx: a serial-line monitor decodes
// frames and compares them against a queue of bytes pushed at stimulus time.
module tb_amber48_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          tx_valid_i = 1'b0;
  logic [7:0]    tx_data_i = '0;
  logic          clr_ovf_i = 1'b0;
  logic          tx_o;
  logic          busy_o;
  logic [CW-1:0] fifo_count_o;
  logic          overflow_o;

  amber48_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tx_valid_i  (tx_valid_i),
    .tx_data_i   (tx_data_i),
    .clr_ovf_i   (clr_ovf_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .fifo_count_o(fifo_count_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int rx_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples each bit mid-period, counted from the first low cycle.
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  always @(negedge clk) begin
    if (rst_i) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx_o === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = '0;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) begin
        check("start_bit", tx_o, 1'b0);
      end else if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB &&
                   ((mon_cnt - CPB / 2) % CPB) == 0) begin
        mon_byte[(mon_cnt - CPB / 2) / CPB - 1] = tx_o;
      end else if (mon_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", tx_o, 1'b1);
        rx_count++;
        if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
        else check("rx_byte", mon_byte, exp_q.pop_front());
      end else if (mon_cnt == 10 * CPB - 1) begin
        mon_active = 1'b0;
      end
    end
  end

  // One-cycle strobe, called #1 after a rising edge; sampled at the next edge.
  task automatic send(input logic [7:0] b);
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    @(posedge clk);
    #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy_o !== 1'b0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_o !== 1'b0) check("idle_timeout", busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int rx0;
    int peak;
    logic [7:0] b2b [3];
    b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF;

    // Reset then idle
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("reset_idle", {tx_o, busy_o, fifo_count_o, overflow_o},
            {1'b1, 1'b0, CW'(0), 1'b0});
      @(posedge clk);
      #1;
    end

    // Single byte: 2-cycle strobe-to-start, 40-cycle frame
    exp_q.push_back(8'h55);
    send(8'h55);
    check("single_cnt_N", fifo_count_o, 1);
    check("single_tx_N", tx_o, 1'b1);
    @(posedge clk);
    #1;
    check("single_tx_N1", tx_o, 1'b0);
    check("single_cnt_N1", fifo_count_o, 0);
    check("single_busy_N1", busy_o, 1'b1);
    wait_idle(100, n);
    check("single_busy_fall", n, 40);
    check("single_rx", rx_count, 1);

    // Back-to-back frames with no gap
    starts.delete();
    rx0  = rx_count;
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(b2b[i]);
      send(b2b[i]);
      if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
    end
    check("b2b_peak", peak, 2);
    wait_idle(300, n);
    check("b2b_dur", n, 119);
    check("b2b_rx", rx_count - rx0, 3);
    check("b2b_starts", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 10 * CPB);
      check("b2b_gap2", starts[2] - starts[1], 10 * CPB);
    end

    // Overflow: 0x06 dropped, flag sticky until clear
    rx0 = rx_count;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      send(8'(i));
      if (i == 5) check("ovf_before", overflow_o, 1'b0);
    end
    check("ovf_set", overflow_o, 1'b1);
    check("ovf_cnt", fifo_count_o, 4);
    repeat (5) @(posedge clk);
    #1;
    check("ovf_sticky", overflow_o, 1'b1);
    clr_ovf_i = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf_i = 1'b0;
    check("ovf_clr", overflow_o, 1'b0);
    wait_idle(400, n);
    check("ovf_rx", rx_count - rx0, 5);

    // Push into a full FIFO on the cycle STOP ends and pops
    rx0 = rx_count;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i));
    end
    check("full_cnt", fifo_count_o, 4);
    repeat (36) @(posedge clk);
    #1;
    check("full_cnt_pre", fifo_count_o, 4);
    exp_q.push_back(8'h15);
    send(8'h15);
    check("full_cnt_post", fifo_count_o, 4);
    check("full_ovf", overflow_o, 1'b0);
    wait_idle(500, n);
    check("full_rx", rx_count - rx0, 6);
    check("sb_left", exp_q.size(), 0);

    // Reset during data bit 3 of 0x00 with two bytes queued
    rx0 = rx_count;
    send(8'h00);
    send(8'h11);
    send(8'h22);
    check("rst_cnt_pre", fifo_count_o, 2);
    repeat (16) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("rst_tx", tx_o, 1'b1);
    check("rst_cnt", fifo_count_o, 0);
    check("rst_busy", busy_o, 1'b0);
    exp_q.delete();
    repeat (100) @(posedge clk);
    #1;
    check("rst_no_frames", rx_count - rx0, 0);
    check("rst_idle_tx", tx_o, 1'b1);
    check("rst_idle_busy", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
